// File: rtl/cpu_regfile_ctrl_pkg.sv
// Shared register-file controller types and sizes.
// Imported by the controller and any block that needs the register-file geometry.
package pck_regfile;

  typedef enum logic {RFC_IDLE, RFC_INIT} rfc_state_t;

  localparam int RF_LAST_FULL = 31;
  localparam int RF_LAST_HALF = 15;

  function automatic logic [4:0] rf_last_idx(input bit half);
    return half ? 5'(RF_LAST_HALF) : 5'(RF_LAST_FULL);
  endfunction

endpackage

// File: rtl/cpu_regfile_ctrl.sv
// Purpose: zero-init sequencer, write-port mux (writeback vs debug) and debug read-port lender.
// Latency: write mux and grant are combinational; debug read data/err 1 cycle after grant.
// Backpressure: o_busy stalls the core during init; debug holds i_dbg_req until o_dbg_gnt.
module cpu_regfile_ctrl
  import pck_regfile::*;
#(
  parameter bit p_half_regfile  = 1'b0,
  parameter bit p_init_on_reset = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  output logic        o_busy,
  input  logic        i_core_halted,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [4:0]  i_core_rd2_addr,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_gnt,
  output logic        o_dbg_rvalid,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dbg_err,
  output logic        o_rf_wr_en,
  output logic [4:0]  o_rf_wr_addr,
  output logic [31:0] o_rf_wr_data,
  output logic [4:0]  o_rf_rd2_addr,
  input  logic [31:0] i_rf_rd2_data
);

  localparam logic [4:0] LAST_IDX  = rf_last_idx(p_half_regfile);
  localparam rfc_state_t RST_STATE = p_init_on_reset ? RFC_INIT : RFC_IDLE;

  rfc_state_t  state, state_nxt;
  logic [4:0]  init_cnt, init_cnt_nxt;
  logic        dbg_gnt;
  logic        dbg_rd_gnt;
  logic        dbg_wr_gnt;
  logic        dbg_oob;

  // A debug write loses the write port to writeback; debug reads never conflict.
  assign dbg_gnt    = (state == RFC_IDLE) & i_dbg_req & i_core_halted & ~(i_dbg_we & i_wb_en);
  assign dbg_rd_gnt = dbg_gnt & ~i_dbg_we;
  assign dbg_wr_gnt = dbg_gnt & i_dbg_we;
  assign dbg_oob    = p_half_regfile & i_dbg_addr[4];

  assign o_dbg_gnt     = dbg_gnt;
  assign o_rf_rd2_addr = dbg_rd_gnt ? i_dbg_addr : i_core_rd2_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= RST_STATE;
      init_cnt <= 5'd1;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    o_busy       = 1'b0;
    o_rf_wr_en   = 1'b0;
    o_rf_wr_addr = 5'd0;
    o_rf_wr_data = 32'd0;
    case (state)
      RFC_INIT: begin
        // x0 is hardwired in the register file, so the sweep starts at 1.
        o_busy       = 1'b1;
        o_rf_wr_en   = 1'b1;
        o_rf_wr_addr = init_cnt;
        if (init_cnt == LAST_IDX) begin
          state_nxt    = RFC_IDLE;
          init_cnt_nxt = 5'd1;
        end else begin
          init_cnt_nxt = init_cnt + 5'd1;
        end
      end
      RFC_IDLE: begin
        if (i_wb_en) begin
          o_rf_wr_en   = 1'b1;
          o_rf_wr_addr = i_wb_addr;
          o_rf_wr_data = i_wb_data;
        end else if (dbg_wr_gnt && !dbg_oob) begin
          o_rf_wr_en   = 1'b1;
          o_rf_wr_addr = i_dbg_addr;
          o_rf_wr_data = i_dbg_wdata;
        end
        if (i_clear) begin
          state_nxt    = RFC_INIT;
          init_cnt_nxt = 5'd1;
        end
      end
      default: state_nxt = RFC_IDLE;
    endcase
  end

  // Debug response: rdata only moves on a read grant; err covers reads and writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dbg_rvalid <= 1'b0;
      o_dbg_rdata  <= 32'd0;
      o_dbg_err    <= 1'b0;
    end else begin
      o_dbg_rvalid <= dbg_rd_gnt;
      o_dbg_err    <= dbg_gnt & dbg_oob;
      if (dbg_rd_gnt) begin
        o_dbg_rdata <= dbg_oob ? 32'd0 : i_rf_rd2_data;
      end
    end
  end

endmodule

// File: doc/cpu_regfile_ctrl.md
Name: cpu_regfile_ctrl

Overview:
Controller that sits between the core and the 2-read/1-write asynchronous register file.
- After reset, and on request, it zero-initialises every register through the write port, one register per cycle.
- It shares the single write port between core writeback and a debug requester.
- It lends read port 2 to the debug requester while the core is halted.
- It exports a busy flag that stalls the core during initialisation.

Parameters:
p_half_regfile, 0, 1 = 16 registers (last index 15), 0 = 32 registers (last index 31); must match the register file instance.
p_init_on_reset, 1, 1 = enter INIT after reset, 0 = enter IDLE directly.

Ports:
i_clk  in  1  global clock
i_rst  in  1  global reset, asynchronous, active-high
i_clear  in  1  request a re-initialisation (pulse)
o_busy  out  1  controller owns the write port; core must stall
i_core_halted  in  1  core halted; debug access permitted
i_wb_en  in  1  core writeback enable
i_wb_addr  in  5  core writeback address
i_wb_data  in  32  core writeback data
i_core_rd2_addr  in  5  core read port 2 address
i_dbg_req  in  1  debug access request
i_dbg_we  in  1  1 = debug write, 0 = debug read
i_dbg_addr  in  5  debug register address
i_dbg_wdata  in  32  debug write data
o_dbg_gnt  out  1  debug request accepted this cycle
o_dbg_rvalid  out  1  debug read data valid (1-cycle pulse)
o_dbg_rdata  out  32  debug read data
o_dbg_err  out  1  out-of-bounds debug access (pulse, aligned with response)
o_rf_wr_en  out  1  to register file write enable
o_rf_wr_addr  out  5  to register file write address
o_rf_wr_data  out  32  to register file write data
o_rf_rd2_addr  out  5  to register file read port 2 address
i_rf_rd2_data  in  32  from register file read port 2 data

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous and active-high.
- Reset values:
  - state = INIT if p_init_on_reset, else IDLE
  - init counter = 1
  - o_dbg_rvalid = 0, o_dbg_rdata = 0, o_dbg_err = 0
  - o_busy follows state, so it is 1 in INIT immediately.
- State INIT:
  - o_busy = 1.
  - o_rf_wr_en = 1, o_rf_wr_addr = counter, o_rf_wr_data = 0.
  - Counter increments each cycle. When counter == last index, next state is IDLE and the counter reloads 1.
  - Duration is exactly 31 cycles (15 when p_half_regfile=1). Register 0 is never written.
  - i_wb_en, i_dbg_req and i_clear are ignored; o_dbg_gnt = 0.
- State IDLE:
  - o_busy = 0.
  - Write port mux, combinational, in priority order:
    1. Writeback: if i_wb_en, pass i_wb_addr and i_wb_data through with o_rf_wr_en = 1.
    2. Otherwise, a granted debug write.
    3. Otherwise, o_rf_wr_en = 0.
  - Debug grant (combinational): o_dbg_gnt = i_dbg_req & i_core_halted & ~(i_dbg_we & i_wb_en).
  - Debug reads do not conflict with writeback.
  - o_rf_rd2_addr = i_dbg_addr when a debug read is granted, else i_core_rd2_addr.
- Debug read response:
  - On the grant edge, register i_rf_rd2_data into o_dbg_rdata.
  - Pulse o_dbg_rvalid the next cycle; latency is 1.
  - Back-to-back grants give back-to-back rvalid pulses.
  - Address 0 reads return 0 (the register file hardwires zero).
- Debug write: o_rf_wr_en = 1 in the grant cycle. No rvalid pulse.
- Out of bounds (p_half_regfile=1 and i_dbg_addr[4]=1):
  - The request is still granted.
  - A write is suppressed (o_rf_wr_en = 0).
  - A read returns o_dbg_rdata = 0.
  - o_dbg_err pulses in the cycle after the grant, for both reads and writes.
- Writeback is never checked; the register file reports its own out-of-bounds condition.
- i_clear in IDLE: next state is INIT; any debug grant in that same cycle still completes.
- i_rst asserted mid-INIT: INIT restarts from register 1.
- i_core_halted low: no grant; i_dbg_req must be held until granted.
- Debug write to address 0: granted and passed to the register file, which drops it.

Decomposition:
- Shared package pck_regfile adds:
  - typedef enum logic {RFC_IDLE, RFC_INIT} rfc_state_t
  - localparam RF_LAST_FULL = 31
  - localparam RF_LAST_HALF = 15
- No sub-module. The register file is instantiated next to this block by the parent.

Test Plan:
1. Reset with p_init_on_reset=1 → o_busy=1 for exactly 31 cycles; writes to addresses 1..31 with data 0 in order; then o_busy=0. Every register reads 0.
2. In IDLE, i_core_halted=1, debug write 0xDEADBEEF to x5 while i_wb_en=0 → o_dbg_gnt=1. Then debug read of x5 → o_dbg_rvalid one cycle later with o_dbg_rdata=0xDEADBEEF.
3. Same cycle: i_wb_en (x7=0x11) and debug write (x7=0x22) → gnt=0 and 0x11 written. The next cycle, with wb idle, grants and writes 0x22; a final read returns 0x22.
4. With p_half_regfile=1, debug read of x20 → granted, o_dbg_rdata=0, o_dbg_err pulses. Debug write 0x55 to x20 → no write to the register file, o_dbg_err pulses.
5. i_clear pulse after x3=0x1234 → 31 cycles of busy, during which i_wb_en writes are ignored; x3 then reads 0.
6. Assert i_rst at INIT counter=10 → counter restarts at 1 and the full 31-cycle init reruns. Debug request with i_core_halted=0 → o_dbg_gnt stays 0.
